timer_sequencer: RTL and testbench
==================================

Name: timer_sequencer

Overview:
Control FSM that sequences the MM:SS countdown counter datapath from debounced one-cycle key pulses and the slide switches. Owns the 1 Hz tick prescaler, the two-step set entry (seconds, then minutes) with BCD clamping, run/pause/expiry sequencing, and display blink timing. Sits between the key_press debouncers and the BCD counter/hex-decoder datapath. Issues only load, decrement and clear strobes; never holds the time value itself.

Parameters:
TICK_DIV, 50000000, clk cycles per countdown tick (1 Hz at 50 MHz); minimum 2.
BLINK_DIV, 12500000, clk cycles per blink-flag toggle; minimum 2.

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous active-low reset
start_stop  input  1  one-cycle start/stop key pulse
set  input  1  one-cycle set key pulse
clear  input  1  one-cycle clear key pulse
sw_tens  input  4  BCD tens entry from switches
sw_ones  input  4  BCD ones entry from switches
cnt_zero  input  1  datapath reports 00:00
ld_sec  output  1  one-cycle strobe: load seconds field from ld_tens/ld_ones
ld_min  output  1  one-cycle strobe: load minutes field from ld_tens/ld_ones
ld_tens  output  4  clamped tens value, valid with ld_sec/ld_min
ld_ones  output  4  clamped ones value, valid with ld_sec/ld_min
cnt_dec  output  1  one-cycle strobe: decrement counter by one second
cnt_clr  output  1  one-cycle strobe: clear counter to 00:00
blink  output  1  display-blank flag while setting
done_led  output  1  flashing expiry indicator
state  output  3  current state encoding (debug/LEDR)

Behaviour:
- All outputs registered; response appears the cycle after the causing input.
- reset_n=0 at a clock edge: state=IDLE, all strobes 0, ld_tens=ld_ones=0, blink=done_led=0, prescaler=0, blink counter=0, blink flag=0. Overrides every input, including mid-run.
- State encoding: IDLE=0, SET_SEC=1, SET_MIN=2, RUN=3, PAUSE=4, DONE=5; 6 and 7 recover to IDLE on the next clock.
- Simultaneous pulses: clear > set > start_stop; lower-priority pulses in the same cycle are dropped.
- clear, any state: cnt_clr=1 for one cycle, prescaler=0, next state IDLE.
- Clamping: ld_ones = min(sw_ones, 9); ld_tens = min(sw_tens, 5). Sampled in the set-pulse cycle.
- IDLE:
  - set -> SET_SEC.
  - start_stop with cnt_zero=0 -> RUN, prescaler=0.
  - start_stop with cnt_zero=1 -> ignored.
- SET_SEC: set -> ld_sec pulse, -> SET_MIN. start_stop ignored.
- SET_MIN: set -> ld_min pulse, -> IDLE. start_stop ignored.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - On the wrap cycle with cnt_zero=0: cnt_dec pulse.
  - cnt_zero=1 in RUN: -> DONE, no cnt_dec issued; covers the counter reaching zero after a decrement.
  - start_stop -> PAUSE, prescaler frozen.
  - set ignored.
- PAUSE:
  - start_stop -> RUN; prescaler resumes from its frozen value, no reset.
  - set -> SET_SEC; prescaler=0.
- DONE: set or start_stop -> IDLE. The counter is not cleared; cnt_clr fires only on clear.
- Blink counter: free-runs 0..BLINK_DIV-1; flag toggles on wrap.
  - blink = flag in SET_SEC/SET_MIN, else 0.
  - done_led = flag in DONE, else 0.
- At most one of ld_sec, ld_min, cnt_dec, cnt_clr is high in any cycle.

Test Plan:
- Reset and set entry (TICK_DIV=4, BLINK_DIV=3): hold reset_n=0 3 cycles -> all outputs 0, state=0. Set pulse -> state=1. Set with sw=7/12 -> ld_sec=1 one cycle, ld_tens=5, ld_ones=9, state=2. Set with sw=0/3 -> ld_min=1, ld_tens=0, ld_ones=3, state=0.
- Run timing: cnt_zero=0, start_stop -> state=3; cnt_dec pulses exactly every 4 cycles, first one 4 cycles after entering RUN.
- Pause mid-tick: start_stop 2 cycles after a cnt_dec -> state=4, no cnt_dec while paused for 10 cycles. start_stop again -> next cnt_dec 2 cycles after resume.
- Expiry: drive cnt_zero=1 in RUN -> state=5 next cycle, no cnt_dec. done_led toggles every 3 cycles. start_stop -> state=0, cnt_clr stays 0.
- Priority and clear: clear+set+start_stop in the same cycle during RUN -> cnt_clr=1 one cycle, state=0, no ld_sec. start_stop in IDLE with cnt_zero=1 -> state stays 0.
- Reset mid-operation: reset_n=0 during SET_MIN with blink=1 -> next cycle state=0, blink=0, no ld_min even if set pulses concurrently.

Source files
------------

// File: rtl/timer_sequencer.sv
// Countdown timer control FSM: key-pulse sequencing, 1 Hz tick prescaler,
// two-step BCD set entry and blink timing. Issues strobes only; holds no time value.
module timer_sequencer #(
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_stop,
    input  logic       set,
    input  logic       clear,
    input  logic [3:0] sw_tens,
    input  logic [3:0] sw_ones,
    input  logic       cnt_zero,
    output logic       ld_sec,
    output logic       ld_min,
    output logic [3:0] ld_tens,
    output logic [3:0] ld_ones,
    output logic       cnt_dec,
    output logic       cnt_clr,
    output logic       blink,
    output logic       done_led,
    output logic [2:0] state
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned BW = $clog2(BLINK_DIV);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET_SEC = 3'd1,
        SET_MIN = 3'd2,
        RUN     = 3'd3,
        PAUSE   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] presc_q, presc_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          flag_q, flag_d;
    logic          ld_sec_d, ld_min_d, cnt_dec_d, cnt_clr_d;
    logic [3:0]    ld_tens_d, ld_ones_d;
    logic [3:0]    tens_clamped, ones_clamped;
    logic          set_eff, ss_eff;

    // Lower-priority pulses are dropped whenever a higher one is present.
    assign set_eff = set & ~clear;
    assign ss_eff  = start_stop & ~set & ~clear;

    assign tens_clamped = (sw_tens > 4'd5) ? 4'd5 : sw_tens;
    assign ones_clamped = (sw_ones > 4'd9) ? 4'd9 : sw_ones;

    assign state = state_q;

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        ld_sec_d  = 1'b0;
        ld_min_d  = 1'b0;
        cnt_dec_d = 1'b0;
        cnt_clr_d = 1'b0;
        ld_tens_d = ld_tens;
        ld_ones_d = ld_ones;

        if (bcnt_q == BW'(BLINK_DIV - 1)) begin
            bcnt_d = '0;
            flag_d = ~flag_q;
        end else begin
            bcnt_d = bcnt_q + BW'(1);
            flag_d = flag_q;
        end

        if (clear) begin
            cnt_clr_d = 1'b1;
            presc_d   = '0;
            state_d   = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (set_eff) begin
                        state_d = SET_SEC;
                    end else if (ss_eff && !cnt_zero) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                SET_SEC: begin
                    if (set_eff) begin
                        ld_sec_d  = 1'b1;
                        ld_tens_d = tens_clamped;
                        ld_ones_d = ones_clamped;
                        state_d   = SET_MIN;
                    end
                end
                SET_MIN: begin
                    if (set_eff) begin
                        ld_min_d  = 1'b1;
                        ld_tens_d = tens_clamped;
                        ld_ones_d = ones_clamped;
                        state_d   = IDLE;
                    end
                end
                RUN: begin
                    // Expiry wins over a pause request and suppresses the tick.
                    if (cnt_zero) begin
                        state_d = DONE;
                    end else if (ss_eff) begin
                        state_d = PAUSE;
                    end else if (presc_q == TW'(TICK_DIV - 1)) begin
                        presc_d   = '0;
                        cnt_dec_d = 1'b1;
                    end else begin
                        presc_d = presc_q + TW'(1);
                    end
                end
                PAUSE: begin
                    if (set_eff) begin
                        state_d = SET_SEC;
                        presc_d = '0;
                    end else if (ss_eff) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    if (set_eff || ss_eff) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            bcnt_q   <= '0;
            flag_q   <= 1'b0;
            ld_sec   <= 1'b0;
            ld_min   <= 1'b0;
            ld_tens  <= '0;
            ld_ones  <= '0;
            cnt_dec  <= 1'b0;
            cnt_clr  <= 1'b0;
            blink    <= 1'b0;
            done_led <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            bcnt_q   <= bcnt_d;
            flag_q   <= flag_d;
            ld_sec   <= ld_sec_d;
            ld_min   <= ld_min_d;
            ld_tens  <= ld_tens_d;
            ld_ones  <= ld_ones_d;
            cnt_dec  <= cnt_dec_d;
            cnt_clr  <= cnt_clr_d;
            blink    <= ((state_d == SET_SEC) || (state_d == SET_MIN)) && flag_d;
            done_led <= (state_d == DONE) && flag_d;
        end
    end

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: directed scenarios then random pulses,
// every cycle compared against a cycle-count based reference model.
module tb_timer_sequencer;

    localparam int TICK  = 4;
    localparam int BLINK = 3;

    logic       clk;
    logic       reset_n, start_stop, set, clear, cnt_zero;
    logic [3:0] sw_tens, sw_ones;
    logic       ld_sec, ld_min, cnt_dec, cnt_clr, blink, done_led;
    logic [3:0] ld_tens, ld_ones;
    logic [2:0] state;

    int passed = 0;
    int total  = 0;

    // Reference model: mode code, RUN cycles since last tick, edges since reset.
    int         m_state = 0;
    int         m_run   = 0;
    int         m_edges = 0;
    logic [3:0] m_tens  = '0;
    logic [3:0] m_ones  = '0;
    logic       e_sec, e_min, e_dec, e_clr, e_rst;

    timer_sequencer #(.TICK_DIV(TICK), .BLINK_DIV(BLINK)) dut (
        .clk(clk), .reset_n(reset_n), .start_stop(start_stop), .set(set),
        .clear(clear), .sw_tens(sw_tens), .sw_ones(sw_ones), .cnt_zero(cnt_zero),
        .ld_sec(ld_sec), .ld_min(ld_min), .ld_tens(ld_tens), .ld_ones(ld_ones),
        .cnt_dec(cnt_dec), .cnt_clr(cnt_clr), .blink(blink), .done_led(done_led),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [3:0] clampv(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_step(input logic rn, c, s, ss, cz, input logic [3:0] t, o);
        logic set_e, ss_e;
        e_sec = 1'b0; e_min = 1'b0; e_dec = 1'b0; e_clr = 1'b0; e_rst = !rn;
        set_e = s && !c;
        ss_e  = ss && !c && !s;
        if (!rn) begin
            m_state = 0; m_run = 0; m_edges = 0; m_tens = '0; m_ones = '0;
        end else begin
            m_edges++;
            if (c) begin
                e_clr = 1'b1; m_run = 0; m_state = 0;
            end else begin
                case (m_state)
                    0: if (set_e) m_state = 1;
                       else if (ss_e && !cz) begin m_state = 3; m_run = 0; end
                    1: if (set_e) begin
                           e_sec = 1'b1; m_tens = clampv(t, 4'd5); m_ones = clampv(o, 4'd9);
                           m_state = 2;
                       end
                    2: if (set_e) begin
                           e_min = 1'b1; m_tens = clampv(t, 4'd5); m_ones = clampv(o, 4'd9);
                           m_state = 0;
                       end
                    3: if (cz) m_state = 5;
                       else if (ss_e) m_state = 4;
                       else begin
                           m_run++;
                           if (m_run == TICK) begin m_run = 0; e_dec = 1'b1; end
                       end
                    4: if (set_e) begin m_state = 1; m_run = 0; end
                       else if (ss_e) m_state = 3;
                    5: if (set_e || ss_e) m_state = 0;
                    default: m_state = 0;
                endcase
            end
        end
    endtask

    task automatic cycle(input logic rn, c, s, ss, cz, input logic [3:0] t, o);
        logic flag;
        reset_n = rn; clear = c; set = s; start_stop = ss; cnt_zero = cz;
        sw_tens = t; sw_ones = o;
        model_step(rn, c, s, ss, cz, t, o);
        @(posedge clk);
        #1;
        flag = ((m_edges / BLINK) % 2) == 1;
        chk("state",    8'(state),    8'(m_state));
        chk("ld_sec",   8'(ld_sec),   8'(e_sec));
        chk("ld_min",   8'(ld_min),   8'(e_min));
        chk("cnt_dec",  8'(cnt_dec),  8'(e_dec));
        chk("cnt_clr",  8'(cnt_clr),  8'(e_clr));
        chk("blink",    8'(blink),    8'(((m_state == 1) || (m_state == 2)) && flag));
        chk("done_led", 8'(done_led), 8'((m_state == 5) && flag));
        chk("strobe_excl", 8'($countones({ld_sec, ld_min, cnt_dec, cnt_clr}) <= 1), 8'd1);
        if (e_sec || e_min || e_rst) begin
            chk("ld_tens", 8'(ld_tens), 8'(m_tens));
            chk("ld_ones", 8'(ld_ones), 8'(m_ones));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1, 0, 0, 0, 0, 4'd0, 4'd0);
    endtask

    initial begin
        logic found;

        // Reset, then two-step set entry with clamping
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 4'd0, 4'd0);
        chk("rst_state", 8'(state), 8'd0);
        cycle(1, 0, 1, 0, 0, 4'd0, 4'd0);
        chk("set_enter", 8'(state), 8'd1);
        cycle(1, 0, 1, 0, 0, 4'd7, 4'd12);
        chk("sec_tens", 8'(ld_tens), 8'd5);
        chk("sec_ones", 8'(ld_ones), 8'd9);
        chk("sec_strobe", 8'(ld_sec), 8'd1);
        idle(1);
        cycle(1, 0, 1, 0, 0, 4'd0, 4'd3);
        chk("min_strobe", 8'(ld_min), 8'd1);
        chk("min_ones", 8'(ld_ones), 8'd3);
        chk("min_state", 8'(state), 8'd0);

        // Run: ticks every TICK cycles
        cycle(1, 0, 0, 1, 0, 4'd0, 4'd0);
        chk("run_state", 8'(state), 8'd3);
        idle(TICK - 1);
        chk("no_early_dec", 8'(cnt_dec), 8'd0);
        idle(1);
        chk("first_dec", 8'(cnt_dec), 8'd1);
        idle(2 * TICK + 1);

        // Pause two cycles after a tick, then resume
        found = 1'b0;
        for (int k = 0; k < 2 * TICK && !found; k++) begin
            idle(1);
            if (cnt_dec === 1'b1) found = 1'b1;
        end
        chk("wait_dec", 8'(found), 8'd1);
        idle(2);
        cycle(1, 0, 0, 1, 0, 4'd0, 4'd0);
        chk("pause_state", 8'(state), 8'd4);
        idle(10);
        cycle(1, 0, 0, 1, 0, 4'd0, 4'd0);
        idle(1);
        chk("resume_no_dec", 8'(cnt_dec), 8'd0);
        idle(1);
        chk("resume_dec", 8'(cnt_dec), 8'd1);

        // Expiry
        cycle(1, 0, 0, 0, 1, 4'd0, 4'd0);
        chk("done_state", 8'(state), 8'd5);
        chk("done_no_dec", 8'(cnt_dec), 8'd0);
        idle(7);
        cycle(1, 0, 0, 1, 0, 4'd0, 4'd0);
        chk("done_exit", 8'(state), 8'd0);
        chk("done_no_clr", 8'(cnt_clr), 8'd0);

        // Priority: clear beats set and start_stop
        cycle(1, 0, 0, 1, 0, 4'd0, 4'd0);
        idle(2);
        cycle(1, 1, 1, 1, 0, 4'd3, 4'd3);
        chk("prio_clr", 8'(cnt_clr), 8'd1);
        chk("prio_state", 8'(state), 8'd0);
        chk("prio_no_ld", 8'(ld_sec), 8'd0);
        cycle(1, 0, 0, 1, 1, 4'd0, 4'd0);
        chk("zero_start_ignored", 8'(state), 8'd0);

        // Reset during SET_MIN while blinking
        cycle(1, 0, 1, 0, 0, 4'd0, 4'd0);
        cycle(1, 0, 1, 0, 0, 4'd2, 4'd4);
        found = 1'b0;
        for (int k = 0; k < 2 * BLINK + 1 && !found; k++) begin
            if (blink === 1'b1) found = 1'b1;
            else idle(1);
        end
        chk("wait_blink", 8'(found), 8'd1);
        cycle(0, 0, 1, 0, 0, 4'd3, 4'd3);
        chk("rst_mid_state", 8'(state), 8'd0);
        chk("rst_mid_blink", 8'(blink), 8'd0);
        chk("rst_mid_no_ld", 8'(ld_min), 8'd0);
        idle(2);

        // Random pulses against the model
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 199) != 0,
                  $urandom_range(0, 29) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) == 0,
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
